// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the register bank's single write port between NUM_REQ writeback
//   sources using round-robin arbitration with a valid/ready handshake per
//   source. The bank write (enable, destination, data) comes from a
//   registered output stage. A 32-entry busy scoreboard lets decode stall on
//   RAW hazards against writes that have not yet committed.
//
// Parameters:
//   NUM_REQ  number of writeback sources (2..8); source 0 wins first after reset
//   DATA_W   register data width
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   req_valid/req_rd/req_data  per-source request, packed source-major
//   req_ready               one-hot combinational grant
//   reserve_valid/reserve_rd   decode marks a destination register pending
//   rs1/rs2 -> rs1_busy/rs2_busy  combinational scoreboard lookup
//   writeRegister/rd/dataToWrite  registered bank write port
//
// Optional feature (macro REGFILE_ARB_STATS_EN):
//   grant_count (16 bits per source), conflict_count (16 bits), stats_clear.
//   All counters saturate at 16'hFFFF; stats_clear has priority.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      reserve_valid,
    input  logic [4:0]                reserve_rd,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      writeRegister,
    output logic [4:0]                rd,
    output logic [DATA_W-1:0]         dataToWrite
`ifdef REGFILE_ARB_STATS_EN
    ,
    input  logic                      stats_clear,
    output logic [16*NUM_REQ-1:0]     grant_count,
    output logic [15:0]               conflict_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    // Unpacked per-source views of the packed request buses
    logic [4:0]        rd_arr_s   [NUM_REQ];
    logic [DATA_W-1:0] data_arr_s [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign rd_arr_s[gi]   = req_rd[5*gi +: 5];
        assign data_arr_s[gi] = req_data[DATA_W*gi +: DATA_W];
    end

    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               write_register_q, write_register_d;
    logic [4:0]         rd_q, rd_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [31:0]        busy_q, busy_d;

    logic [IDX_W-1:0]   cand_idx_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_any_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [4:0]         grant_rd_s;
    logic [DATA_W-1:0]  grant_data_s;

    // Round-robin search starting just after the last granted source
    always_comb begin
        cand_idx_s  = last_grant_q;
        grant_idx_s = last_grant_q;
        grant_any_s = 1'b0;
        grant_oh_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx_s = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_any_s && req_valid[cand_idx_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_idx_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        grant_oh_s[grant_idx_s] = grant_any_s;
    end

    assign req_ready    = grant_oh_s;
    assign grant_rd_s   = rd_arr_s[grant_idx_s];
    assign grant_data_s = data_arr_s[grant_idx_s];

    // Next-state for pointer, bank write stage and scoreboard
    always_comb begin
        busy_d = busy_q;
        if (grant_any_s) begin
            last_grant_d     = grant_idx_s;
            // A write to x0 is consumed but never strobes the bank
            write_register_d = (grant_rd_s != 5'd0);
            rd_d             = grant_rd_s;
            data_d           = grant_data_s;
            busy_d[grant_rd_s] = 1'b0;
        end else begin
            last_grant_d     = last_grant_q;
            write_register_d = 1'b0;
            rd_d             = rd_q;
            data_d           = data_q;
        end
        // Applied after the clear so a same-cycle reserve keeps the bit set
        if (reserve_valid) begin
            busy_d[reserve_rd] = 1'b1;
        end else begin
            busy_d[reserve_rd] = busy_d[reserve_rd];
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q     <= LAST_RST;
            write_register_q <= 1'b0;
            rd_q             <= 5'd0;
            data_q           <= '0;
            busy_q           <= 32'd0;
        end else begin
            last_grant_q     <= last_grant_d;
            write_register_q <= write_register_d;
            rd_q             <= rd_d;
            data_q           <= data_d;
            busy_q           <= busy_d;
        end
    end

    assign writeRegister = write_register_q;
    assign rd            = rd_q;
    assign dataToWrite   = data_q;
    assign rs1_busy      = busy_q[rs1];
    assign rs2_busy      = busy_q[rs2];

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        multi_valid_s;

    assign multi_valid_s = ($countones(req_valid) > 1);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [15:0] grant_cnt_q, grant_cnt_d;

        // Saturating per-source grant counter, clear has priority
        always_comb begin
            if (stats_clear) begin
                grant_cnt_d = 16'd0;
            end else if (grant_oh_s[gi] && (grant_cnt_q != 16'hFFFF)) begin
                grant_cnt_d = grant_cnt_q + 16'd1;
            end else begin
                grant_cnt_d = grant_cnt_q;
            end
        end

        // Per-source grant counter register
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                grant_cnt_q <= 16'd0;
            end else begin
                grant_cnt_q <= grant_cnt_d;
            end
        end

        assign grant_count[16*gi +: 16] = grant_cnt_q;
    end

    // Saturating count of cycles with two or more sources requesting
    always_comb begin
        if (stats_clear) begin
            conflict_cnt_d = 16'd0;
        end else if (multi_valid_s && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Conflict counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt_q <= 16'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_count = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed testbench for regfile_write_arbiter. A behavioural model tracks the
// round-robin pointer, scoreboard and bank write stage; a negedge process
// compares the DUT against it every cycle, and directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [5*N-1:0]  req_rd = '0;
    logic [DW*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            reserve_valid = 1'b0;
    logic [4:0]      reserve_rd = 5'd0;
    logic [4:0]      rs1 = 5'd0;
    logic [4:0]      rs2 = 5'd0;
    logic            rs1_busy, rs2_busy;
    logic            writeRegister;
    logic [4:0]      rd;
    logic [DW-1:0]   dataToWrite;
`ifdef REGFILE_ARB_STATS_EN
    logic            stats_clear = 1'b0;
    logic [16*N-1:0] grant_count;
    logic [15:0]     conflict_count;
`endif

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .reserve_valid (reserve_valid),
        .reserve_rd    (reserve_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .writeRegister (writeRegister),
        .rd            (rd),
        .dataToWrite   (dataToWrite)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .stats_clear   (stats_clear),
        .grant_count   (grant_count),
        .conflict_count(conflict_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_last = N - 1;
    bit   [31:0] m_busy = '0;
    bit          m_we = 1'b0;
    bit   [4:0]  m_rd = '0;
    bit [DW-1:0] m_data = '0;
    int          m_g;
    int          m_gc [N];
    int          m_conf = 0;

    // First valid source after 'last', wrapping modulo N; -1 when none
    function automatic int model_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always_comb m_g = model_grant(req_valid, m_last);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_last <= N - 1;
            m_busy <= '0;
            m_we   <= 1'b0;
            m_rd   <= '0;
            m_data <= '0;
            m_conf <= 0;
            for (int i = 0; i < N; i++) m_gc[i] <= 0;
        end else begin
            if (m_g >= 0) begin
                m_last <= m_g;
                m_we   <= (req_rd[5*m_g +: 5] != 5'd0);
                m_rd   <= req_rd[5*m_g +: 5];
                m_data <= req_data[DW*m_g +: DW];
                m_busy[req_rd[5*m_g +: 5]] <= 1'b0;
            end else begin
                m_we <= 1'b0;
            end
            if (reserve_valid && reserve_rd != 5'd0) m_busy[reserve_rd] <= 1'b1;
`ifdef REGFILE_ARB_STATS_EN
            if (stats_clear) begin
                m_conf <= 0;
                for (int i = 0; i < N; i++) m_gc[i] <= 0;
            end else begin
                if ($countones(req_valid) >= 2 && m_conf < 65535) m_conf <= m_conf + 1;
                if (m_g >= 0 && m_gc[m_g] < 65535) m_gc[m_g] <= m_gc[m_g] + 1;
            end
`endif
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        logic [N-1:0] exp_ready;
        exp_ready = '0;
        if (m_g >= 0) exp_ready[m_g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("writeRegister", 64'(writeRegister), 64'(m_we));
        chk("rd", 64'(rd), 64'(m_rd));
        chk("dataToWrite", 64'(dataToWrite), 64'(m_data));
        chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1] && rs1 != 5'd0));
        chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2] && rs2 != 5'd0));
`ifdef REGFILE_ARB_STATS_EN
        chk("conflict_count", 64'(conflict_count), 64'(m_conf));
        for (int i = 0; i < N; i++)
            chk("grant_count", 64'(grant_count[16*i +: 16]), 64'(m_gc[i]));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic set_src(input int i, input logic [4:0] r, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_rd[5*i +: 5]      = r;
        req_data[DW*i +: DW]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int gcount [N];
        for (int i = 0; i < N; i++) gcount[i] = 0;

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_writeRegister", 64'(writeRegister), 64'd0);
        chk("reset_rd", 64'(rd), 64'd0);
        chk("reset_data", 64'(dataToWrite), 64'd0);
        reset_n = 1'b1;

        // Single request from source 1
        set_src(1, 5'd5, 32'hDEADBEEF);
        #1 chk("t1_ready", 64'(req_ready), 64'b010);
        next_cycle();
        req_valid = '0;
        chk("t1_we", 64'(writeRegister), 64'd1);
        chk("t1_rd", 64'(rd), 64'd5);
        chk("t1_data", 64'(dataToWrite), 64'hDEADBEEF);
        next_cycle();
        chk("t1_we_drop", 64'(writeRegister), 64'd0);

        // Write to x0 from source 2: consumed, no strobe, pointer advances
        set_src(2, 5'd0, 32'h1234);
        #1 chk("t3_ready", 64'(req_ready), 64'b100);
        next_cycle();
        req_valid = '0;
        chk("t3_we", 64'(writeRegister), 64'd0);
        set_src(0, 5'd1, 32'h11);
        set_src(2, 5'd2, 32'h22);
        #1 chk("t3_ptr", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = '0;
        chk("t3_rd", 64'(rd), 64'd1);
        set_src(2, 5'd4, 32'h44);
        next_cycle();
        req_valid = '0;

        // All three sources valid for six cycles
        set_src(0, 5'd10, 32'hA0);
        set_src(1, 5'd11, 32'hA1);
        set_src(2, 5'd12, 32'hA2);
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] e;
            e = '0;
            e[i % 3] = 1'b1;
            #1 chk("t2_order", 64'(req_ready), 64'(e));
            for (int s = 0; s < N; s++) if (req_ready[s]) gcount[s]++;
            next_cycle();
        end
        req_valid = '0;
        for (int s = 0; s < N; s++) chk("t2_count", 64'(gcount[s]), 64'd2);

        // Scoreboard set / clear / same-cycle set-wins
        reserve_valid = 1'b1;
        reserve_rd    = 5'd7;
        rs1           = 5'd7;
        next_cycle();
        reserve_valid = 1'b0;
        chk("t4_busy_set", 64'(rs1_busy), 64'd1);
        set_src(0, 5'd7, 32'h77);
        next_cycle();
        req_valid = '0;
        chk("t4_busy_clr", 64'(rs1_busy), 64'd0);
        set_src(0, 5'd7, 32'h78);
        reserve_valid = 1'b1;
        rs2           = 5'd7;
        next_cycle();
        req_valid     = '0;
        reserve_valid = 1'b0;
        chk("t4_set_wins1", 64'(rs1_busy), 64'd1);
        chk("t4_set_wins2", 64'(rs2_busy), 64'd1);
        chk("t4_we", 64'(writeRegister), 64'd1);
        rs2 = 5'd0;
        #1 chk("t4_x0_busy", 64'(rs2_busy), 64'd0);

        // Asynchronous reset mid-operation
        reserve_valid = 1'b1;
        reserve_rd    = 5'd3;
        set_src(0, 5'd9, 32'h99);
        next_cycle();
        req_valid     = '0;
        reserve_valid = 1'b0;
        rs1           = 5'd3;
        chk("t5_we_pre", 64'(writeRegister), 64'd1);
        #1 chk("t5_busy_pre", 64'(rs1_busy), 64'd1);
        #1 reset_n = 1'b0;
        #1 chk("t5_we_rst", 64'(writeRegister), 64'd0);
        chk("t5_busy_rst", 64'(rs1_busy), 64'd0);
        next_cycle();
        reset_n = 1'b1;
        set_src(0, 5'd1, 32'h1);
        set_src(1, 5'd2, 32'h2);
        set_src(2, 5'd3, 32'h3);
        #1 chk("t5_first", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = '0;

`ifdef REGFILE_ARB_STATS_EN
        // Counters: reset to zero above except one grant just made; clear first
        stats_clear = 1'b1;
        next_cycle();
        stats_clear = 1'b0;
        set_src(0, 5'd1, 32'h1);
        set_src(1, 5'd2, 32'h2);
        repeat (3) next_cycle();
        req_valid = '0;
        chk("st_conflict", 64'(conflict_count), 64'd3);
        chk("st_grant_sum", 64'(grant_count[15:0]) + 64'(grant_count[31:16]), 64'd3);
        stats_clear = 1'b1;
        next_cycle();
        stats_clear = 1'b0;
        chk("st_clr_conf", 64'(conflict_count), 64'd0);
        chk("st_clr_grant", 64'(grant_count), 64'd0);
`endif

        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register bank's single write port between NUM_REQ writeback sources (ALU result, load data, CSR/debug).
- Uses round-robin arbitration with a valid/ready handshake per source.
- Drives the bank's write enable, destination register and data from a registered output stage.
- Keeps a 32-entry busy scoreboard so decode can stall on RAW hazards against writes not yet committed.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 has highest priority after reset.
- DATA_W, 32, width of register data.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-source write request.
- req_rd  in  5*NUM_REQ  per-source destination register; source i occupies bits [5i+4:5i].
- req_data  in  DATA_W*NUM_REQ  per-source write data; source i occupies bits [DATA_W*i+DATA_W-1:DATA_W*i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- reserve_valid  in  1  decode marks reserve_rd as pending.
- reserve_rd  in  5  register being reserved.
- rs1, rs2  in  5 each  decode source registers to check.
- rs1_busy, rs2_busy  out  1 each  combinational scoreboard lookup.
- writeRegister  out  1  write enable to the register bank (registered).
- rd  out  5  destination register to the bank (registered).
- dataToWrite  out  DATA_W  data to the bank (registered).

Behaviour:
- Reset (async, while reset_n=0):
  - writeRegister=0, rd=0, dataToWrite=0.
  - All busy bits cleared.
  - Round-robin pointer last_grant=NUM_REQ-1, so source 0 wins first.
- req_ready is combinational from req_valid and last_grant.
  - At most one bit is high.
  - It is high only for the first valid source searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - All zero when no source is valid.
  - req_ready does not depend on req_rd or req_data.
- On posedge with grant g:
  - writeRegister<=1, rd<=req_rd[g], dataToWrite<=req_data[g], last_grant<=g.
  - Latency from handshake to bank write strobe is 1 cycle. The bank samples on the following negedge, so the write is visible to reads on the next posedge.
- On posedge with no grant: writeRegister<=0. rd and dataToWrite hold their previous values. last_grant holds.
- Destination x0:
  - The grant is still given and the handshake completes, consuming the request.
  - writeRegister<=0 for that cycle.
  - The pointer advances as for a normal grant.
- Every source is backpressure-tolerant: a source must hold valid, rd and data stable until it sees ready.
- Scoreboard (busy[31:1]; busy[0] is hardwired 0):
  - Set: reserve_valid && reserve_rd!=0 sets busy[reserve_rd] on posedge.
  - Clear: a granted write with rd r!=0 clears busy[r] on the same posedge as the grant. The value reaches the bank half a cycle later; decode must use bypass or accept one bubble.
  - Same register set and cleared in one cycle: set wins and busy stays 1 (the newer producer owns it).
  - A write to a register that is not busy is legal; busy stays 0.
  - rsN_busy = busy[rsN]; always 0 for rsN=0.
- Reset asserted mid-operation: any pending output write is dropped (writeRegister forced 0 immediately) and the scoreboard is cleared.
- Arithmetic: the pointer increments modulo NUM_REQ and wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined, add these ports:
  - grant_count out 16*NUM_REQ: per-source saturating count of granted transfers.
  - conflict_count out 16: saturating count of cycles with two or more req_valid high.
  - stats_clear in 1: synchronous zero of all counters; takes priority over increment.
- All counters reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then source 1 requests rd=5, data=32'hDEADBEEF → req_ready=3'b010 the same cycle; next cycle writeRegister=1, rd=5, dataToWrite=32'hDEADBEEF; following cycle writeRegister=0.
- Sources 0, 1 and 2 all hold valid for 6 cycles → grant order 0,1,2,0,1,2; each source receives exactly 2 grants.
- Source 2 requests rd=0, data=32'h1234 → handshake completes and writeRegister stays 0; a subsequent request from source 0 is granted (pointer advanced to 2).
- reserve_rd=7, then rs1=7 → rs1_busy=1; source 0 writes rd=7 → busy cleared after that posedge. In another cycle, reserve rd=7 in the same cycle as a write to rd=7 → rs1_busy stays 1.
- Assert reset_n=0 asynchronously while writeRegister=1 with busy[3]=1 → writeRegister=0 and rs1_busy(rs1=3)=0 immediately; after release, source 0 wins first.
- With REGFILE_ARB_STATS_EN defined: 3 cycles with sources 0 and 1 both valid → conflict_count=3 and grant_count[0]+grant_count[1]=3; stats_clear → all counters 0.
